approx_top_core: RTL and testbench

- Sequential fixed-point approximation of exp(x) by truncated Taylor series: y = sum over n = 0..N of x^n/n!.
- Input and output are signed Q4.12. The caller selects the number of series terms N.
- One new term is produced per clock; start/busy/valid handshake.
- Sits as a standalone arithmetic engine behind a simple request interface.

---
 rtl/approx_pkg.sv | 34 +++
 rtl/approx_if.sv | 24 ++
 rtl/approx_term_mac.sv | 35 +++
 rtl/approx_top_core.sv | 102 ++++++++++
 tb/tb_approx_top_core.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/approx_pkg.sv
// Shared constants, state encoding and reciprocal table for the exp(x)
// Taylor-series engine.
package approx_pkg;

  // Q4.12 fixed-point format
  localparam int FRAC = 12;
  localparam int ONE  = 4096;

  // Right shift applied after the reciprocal multiply (RECIP is 65536/n)
  localparam int RECIP_SHIFT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // round(65536/n) as 17-bit unsigned constants; n=0 never occurs.
  function automatic logic [16:0] recip(input logic [2:0] n);
    logic [16:0] r;
    case (n)
      3'd1:    r = 17'd65536;
      3'd2:    r = 17'd32768;
      3'd3:    r = 17'd21845;
      3'd4:    r = 17'd16384;
      3'd5:    r = 17'd13107;
      3'd6:    r = 17'd10923;
      3'd7:    r = 17'd9362;
      default: r = 17'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/approx_if.sv
// Request/response interface of the exp(x) engine.
// Handshake: start_i is a request pulse accepted only on a clock edge where
// busy_o is low; x_i/nIt_i are sampled on that edge. valid_o pulses for one
// cycle while y_o presents the new result; y_o holds it afterwards.
interface approx_if #(
  parameter int W = 16
);
  logic [W-1:0] x_i;
  logic [2:0]   nIt_i;
  logic         start_i;
  logic         busy_o;
  logic [W-1:0] y_o;
  logic         valid_o;

  modport master (
    output x_i, nIt_i, start_i,
    input  busy_o, y_o, valid_o
  );

  modport slave (
    input  x_i, nIt_i, start_i,
    output busy_o, y_o, valid_o
  );
endinterface

// File: rtl/approx_term_mac.sv
// One series step: next term = ((term*x)>>>FRAC * RECIP[n])>>>16,
// accumulated into acc. Purely combinational; the top registers the results.
module approx_term_mac
  import approx_pkg::*;
#(
  parameter int W     = 16,
  parameter int ACC_W = 20
) (
  input  logic signed [ACC_W-1:0] term,
  input  logic signed [W-1:0]     x,
  input  logic        [2:0]       n,
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [ACC_W-1:0] term_next,
  output logic signed [ACC_W-1:0] acc_next
);

  localparam int P1_W = ACC_W + W;
  localparam int P2_W = ACC_W + 18;

  logic signed [P1_W-1:0]  prod1;
  logic signed [ACC_W-1:0] p;
  logic signed [17:0]      recip_s;
  logic signed [P2_W-1:0]  prod2;

  // Full-precision signed multiplies, floor shifts, truncation to ACC_W
  always_comb begin
    prod1     = P1_W'(term) * P1_W'(x);
    p         = ACC_W'(prod1 >>> FRAC);
    recip_s   = $signed({1'b0, recip(n)});
    prod2     = P2_W'(p) * P2_W'(recip_s);
    term_next = ACC_W'(prod2 >>> RECIP_SHIFT);
    acc_next  = acc + term_next;
  end

endmodule

// File: rtl/approx_top_core.sv
// Sequential exp(x) by truncated Taylor series: FSM, request handshake and
// output saturation. One series term is added per CALC cycle.
module approx_top_core
  import approx_pkg::*;
#(
  parameter int W     = 16,
  parameter int ACC_W = 20
) (
  input  logic       clk,
  input  logic       rst,
  approx_if.slave    bus,
  output state_t     state_dbg
);

  localparam int Y_MAX = (1 << (W - 1)) - 1;

  state_t                  state, state_next;
  logic signed [W-1:0]     x_q;
  logic        [2:0]       n_max;
  logic        [2:0]       n;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] term_next;
  logic signed [ACC_W-1:0] acc_next;
  logic        [W-1:0]     y_q;
  logic        [W-1:0]     y_sat;

  approx_term_mac #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_mac (
    .term      (term),
    .x         (x_q),
    .n         (n),
    .acc       (acc),
    .term_next (term_next),
    .acc_next  (acc_next)
  );

  // State register; reset aborts any computation in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic; N=0 needs no series step so it goes straight to DONE
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start_i) state_next = (bus.nIt_i == 3'd0) ? DONE : CALC;
      CALC: if (n == n_max)  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers: latch operands on acceptance, step the series in CALC,
  // capture the saturated result in DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q   <= '0;
      n_max <= '0;
      n     <= '0;
      term  <= '0;
      acc   <= '0;
      y_q   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start_i) begin
          x_q   <= bus.x_i;
          n_max <= bus.nIt_i;
          term  <= ACC_W'(ONE);
          acc   <= ACC_W'(ONE);
          n     <= 3'd1;
        end
        CALC: begin
          term <= term_next;
          acc  <= acc_next;
          n    <= n + 3'd1;
        end
        DONE: y_q <= y_sat;
        default: ;
      endcase
    end
  end

  // exp(x) is never negative, so negative sums clamp to zero
  always_comb begin
    y_sat = acc[W-1:0];
    if (acc < 0)                       y_sat = '0;
    else if (acc > ACC_W'(Y_MAX))      y_sat = W'(Y_MAX);
  end

  // Result is presented during DONE and held in y_q afterwards
  always_comb begin
    bus.busy_o  = (state != IDLE);
    bus.valid_o = (state == DONE);
    bus.y_o     = (state == DONE) ? y_sat : y_q;
    state_dbg   = state;
  end

endmodule

// File: tb/tb_approx_top_core.sv
// Directed bench for approx_top_core with hand-computed Q4.12 results.
module tb_approx_top_core;
  import approx_pkg::*;

  logic   clk;
  logic   rst;
  state_t state_dbg;
  int     n_checks;
  int     n_fail;

  approx_if #(.W(16)) bus ();

  approx_top_core #(.W(16), .ACC_W(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock and global time limit
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE and check latency, result and pulse width
  task automatic run_op(input string tag, input logic [15:0] x, input logic [2:0] nn,
                        input logic [15:0] exp_y);
    int lat;
    @(negedge clk);
    bus.x_i     = x;
    bus.nIt_i   = nn;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    lat = 1;
    check({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
    while (!bus.valid_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(nn) + 32'd1);
    check({tag, "_y"}, 32'(bus.y_o), 32'(exp_y));
    @(negedge clk);
    check({tag, "_vpulse"}, 32'(bus.valid_o), 32'd0);
    check({tag, "_idle"}, 32'(bus.busy_o), 32'd0);
    check({tag, "_hold"}, 32'(bus.y_o), 32'(exp_y));
  endtask

  initial begin
    int lat;
    int pulses;
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.x_i     = '0;
    bus.nIt_i   = '0;

    // Asynchronous reset
    #2 rst = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_valid", 32'(bus.valid_o), 32'd0);
    check("rst_y", 32'(bus.y_o), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed vectors
    run_op("x0_n7",    16'h0000, 3'd7, 16'd4096);
    run_op("x1_n7",    16'h1000, 3'd7, 16'd11130);
    run_op("x1_n1",    16'h1000, 3'd1, 16'd8192);
    run_op("any_n0",   16'h1234, 3'd0, 16'd4096);
    run_op("xm1_n7",   16'hF000, 3'd7, 16'd1505);
    run_op("xmax_n7",  16'h7FFF, 3'd7, 16'h7FFF);
    run_op("xmin_n1",  16'h8000, 3'd1, 16'h0000);

    // Start while busy with different operands is ignored
    @(negedge clk);
    bus.x_i     = 16'h1000;
    bus.nIt_i   = 3'd7;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.x_i     = 16'hF000;
    bus.nIt_i   = 3'd3;
    lat = 1;
    @(negedge clk);
    lat++;
    bus.start_i = 1'b1;
    check("busy_y_held", 32'(bus.y_o), 32'h0000);
    @(negedge clk);
    lat++;
    bus.start_i = 1'b0;
    while (!bus.valid_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ign_lat", 32'(lat), 32'd8);
    check("ign_y", 32'(bus.y_o), 32'd11130);
    @(negedge clk);
    check("ign_no_restart", 32'(bus.busy_o), 32'd0);

    // start_i held high: one pulse every three cycles
    bus.x_i     = 16'h1000;
    bus.nIt_i   = 3'd1;
    bus.start_i = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (bus.valid_o) begin
        pulses++;
        check("b2b_y", 32'(bus.y_o), 32'd8192);
      end
      if (i == 9) bus.start_i = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.valid_o) pulses++;
    end
    check("b2b_pulses", 32'(pulses), 32'd3);

    // Reset mid-computation aborts with no result
    @(negedge clk);
    bus.x_i     = 16'h1000;
    bus.nIt_i   = 3'd7;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    check("mid_rst_valid", 32'(bus.valid_o), 32'd0);
    check("mid_rst_y", 32'(bus.y_o), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.valid_o) pulses++;
    end
    check("mid_rst_no_valid", 32'(pulses), 32'd0);

    // Recovery after reset: x=0.5, N=2 -> 1 + 0.5 + 0.125
    run_op("xhalf_n2", 16'h0800, 3'd2, 16'd6656);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
